// File: rtl/mcpu_trace_buffer.sv
// rtl/mcpu_trace_buffer.sv - retired-instruction trace recorder with circular buffer and pop port
// Optional timestamp prefix on each record when MCPU_TRACE_TS_EN is defined.
module mcpu_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter bit STOP_FULL = 1'b0,
  parameter int TS_W      = 16,
  localparam int AW       = $clog2(DEPTH),
`ifdef MCPU_TRACE_TS_EN
  localparam bit TS_ON    = 1'b1,
`else
  localparam bit TS_ON    = 1'b0,
`endif
  localparam int REC_W    = 102 + (TS_ON ? TS_W : 0)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [31:0]      PCOUT,
  input  logic [31:0]      IDataOut,
  input  logic             PCWre,
  input  logic             RegWre,
  input  logic [4:0]       WriteReg,
  input  logic [31:0]      WriteData,
  input  logic             arm,
  input  logic             stop,
  input  logic             clear,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  input  logic             rd_pop,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    FULL    = 2'b11
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t           st, st_next;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_next;
  logic [REC_W-1:0] mem [DEPTH];
  logic [REC_W-1:0] rec;

  logic trig_hit, wr_req, is_full, pop_ok, do_wr, do_pop, overwrite, drop;

`ifdef MCPU_TRACE_TS_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  assign rec = {ts, RegWre, WriteReg, WriteData, IDataOut, PCOUT};
`else
  assign rec = {RegWre, WriteReg, WriteData, IDataOut, PCOUT};
`endif

  // The matching instruction in ARMED is itself the first record of the session.
  assign trig_hit  = (st == ARMED) && PCWre && (PCOUT == trig_pc);
  assign wr_req    = PCWre && ((st == CAPTURE) || (st == FULL) || trig_hit);
  assign is_full   = (count == FULL_CNT);
  assign pop_ok    = rd_pop && (count != '0);
  assign do_pop    = pop_ok && !clear;
  assign do_wr     = wr_req && !clear && (!is_full || pop_ok || !STOP_FULL);
  assign overwrite = do_wr && is_full && !pop_ok;
  assign drop      = wr_req && !clear && is_full && !pop_ok && STOP_FULL;

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (!overwrite) begin
      case ({do_wr, do_pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    st_next = st;
    if (stop) begin
      st_next = IDLE;
    end else begin
      case (st)
        IDLE:    if (arm) st_next = trig_en ? ARMED : CAPTURE;
        ARMED:   if (trig_hit)
                   st_next = (STOP_FULL && count_next == FULL_CNT) ? FULL : CAPTURE;
        default: if (!clear)
                   st_next = (STOP_FULL && count_next == FULL_CNT) ? FULL : CAPTURE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      st       <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      st    <= st_next;
      count <= count_next;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        // Wrap mode drops the oldest record by advancing the read side.
        if (do_pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
        if (overwrite || drop) overflow <= 1'b1;
        rd_valid <= do_pop;
        if (do_pop) rd_data <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= rec;
  end

  assign state = st;

endmodule

// File: tb/tb_mcpu_trace_buffer.sv
// tb/tb_mcpu_trace_buffer.sv - directed self-checking bench for mcpu_trace_buffer
// Two DEPTH=4 instances share stimulus: one in wrap mode, one in stop-on-full mode.
module tb_mcpu_trace_buffer;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic [31:0]  PCOUT = '0, IDataOut = '0, WriteData = '0, trig_pc = '0;
  logic         PCWre = 1'b0, RegWre = 1'b0, arm = 1'b0, stop = 1'b0, clear = 1'b0;
  logic         trig_en = 1'b0, rd_pop = 1'b0;
  logic [4:0]   WriteReg = '0;

  logic         vw, vs, ow, os;
  logic [101:0] dw, ds;
  logic [2:0]   cw, cs;
  logic [1:0]   sw, ss;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mcpu_trace_buffer #(.DEPTH(4), .STOP_FULL(1'b0), .TS_W(16)) dut_w (
    .CLK(CLK), .Reset(Reset), .PCOUT(PCOUT), .IDataOut(IDataOut), .PCWre(PCWre),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData), .arm(arm), .stop(stop),
    .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc), .rd_pop(rd_pop),
    .rd_valid(vw), .rd_data(dw), .count(cw), .overflow(ow), .state(sw)
  );

  mcpu_trace_buffer #(.DEPTH(4), .STOP_FULL(1'b1), .TS_W(16)) dut_s (
    .CLK(CLK), .Reset(Reset), .PCOUT(PCOUT), .IDataOut(IDataOut), .PCWre(PCWre),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData), .arm(arm), .stop(stop),
    .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc), .rd_pop(rd_pop),
    .rd_valid(vs), .rd_data(ds), .count(cs), .overflow(os), .state(ss)
  );

  function automatic logic [101:0] rec(input logic [31:0] pc);
    return {1'b1, pc[6:2], ~pc, 32'hA500_0000 ^ pc, pc};
  endfunction

  task automatic cycle(input bit ret, input logic [31:0] pc, input bit pop,
                       input bit a, input bit s, input bit c);
    PCWre = ret; RegWre = ret; PCOUT = pc; IDataOut = 32'hA500_0000 ^ pc;
    WriteReg = pc[6:2]; WriteData = ~pc;
    rd_pop = pop; arm = a; stop = s; clear = c;
    @(posedge CLK); #1;
    PCWre = 1'b0; RegWre = 1'b0; rd_pop = 1'b0; arm = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; #2; Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sw !== 2'd0 || cw !== 3'd0 || ow !== 1'b0 || vw !== 1'b0 || dw !== '0) begin
      errors++; $display("FAIL reset_w got st=%0d cnt=%0d ovf=%0d v=%0d d=%h exp 0", sw, cw, ow, vw, dw); end
    checks++; if (ss !== 2'd0 || cs !== 3'd0 || os !== 1'b0 || vs !== 1'b0) begin
      errors++; $display("FAIL reset_s got st=%0d cnt=%0d ovf=%0d v=%0d exp 0", ss, cs, os, vs); end
    Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    do_reset();
    trig_en = 1'b0;
    cycle(0, 0, 0, 1, 0, 0);
    checks++; if (sw !== 2'd2) begin errors++; $display("FAIL basic_state got %0d exp 2", sw); end
    for (int i = 0; i < 3; i++) cycle(1, 32'(i * 4), 0, 0, 0, 0);
    checks++; if (cw !== 3'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", cw); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      checks++; if (vw !== 1'b1 || dw !== rec(32'(i * 4))) begin
        errors++; $display("FAIL basic_pop%0d got v=%0d d=%h exp v=1 d=%h", i, vw, dw, rec(32'(i * 4))); end
    end
    checks++; if (cw !== 3'd0) begin errors++; $display("FAIL basic_drained got %0d exp 0", cw); end
  endtask

  task automatic test_trigger();
    logic [31:0] pcs [4] = '{32'h08, 32'h0C, 32'h10, 32'h14};
    logic [1:0]  est [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [2:0]  ecnt[4] = '{3'd0, 3'd0, 3'd1, 3'd2};
    do_reset();
    trig_en = 1'b1; trig_pc = 32'h10;
    cycle(0, 0, 0, 1, 0, 0);
    trig_en = 1'b0;
    checks++; if (sw !== 2'd1) begin errors++; $display("FAIL trig_armed got %0d exp 1", sw); end
    for (int i = 0; i < 4; i++) begin
      cycle(1, pcs[i], 0, 0, 0, 0);
      checks++; if (sw !== est[i] || cw !== ecnt[i]) begin
        errors++; $display("FAIL trig_step%0d got st=%0d cnt=%0d exp st=%0d cnt=%0d", i, sw, cw, est[i], ecnt[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      checks++; if (vw !== 1'b1 || dw[31:0] !== pcs[i + 2]) begin
        errors++; $display("FAIL trig_pop%0d got v=%0d pc=%h exp v=1 pc=%h", i, vw, dw[31:0], pcs[i + 2]); end
    end
  endtask

  task automatic test_wrap_stop();
    logic [31:0] epw[4] = '{32'h08, 32'h0C, 32'h10, 32'h14};
    logic [31:0] eps[4] = '{32'h00, 32'h04, 32'h08, 32'h0C};
    do_reset();
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), 0, 0, 0, 0);
    checks++; if (ss !== 2'd3 || os !== 1'b0 || cs !== 3'd4) begin
      errors++; $display("FAIL stop_full got st=%0d ovf=%0d cnt=%0d exp st=3 ovf=0 cnt=4", ss, os, cs); end
    for (int i = 4; i < 6; i++) cycle(1, 32'(i * 4), 0, 0, 0, 0);
    checks++; if (cw !== 3'd4 || ow !== 1'b1 || sw !== 2'd2) begin
      errors++; $display("FAIL wrap_ovf got cnt=%0d ovf=%0d st=%0d exp cnt=4 ovf=1 st=2", cw, ow, sw); end
    checks++; if (cs !== 3'd4 || os !== 1'b1 || ss !== 2'd3) begin
      errors++; $display("FAIL stop_ovf got cnt=%0d ovf=%0d st=%0d exp cnt=4 ovf=1 st=3", cs, os, ss); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      checks++; if (vw !== 1'b1 || dw[31:0] !== epw[i]) begin
        errors++; $display("FAIL wrap_pop%0d got v=%0d pc=%h exp v=1 pc=%h", i, vw, dw[31:0], epw[i]); end
      checks++; if (vs !== 1'b1 || ds[31:0] !== eps[i]) begin
        errors++; $display("FAIL stop_pop%0d got v=%0d pc=%h exp v=1 pc=%h", i, vs, ds[31:0], eps[i]); end
      if (i == 0) begin
        checks++; if (ss !== 2'd2) begin errors++; $display("FAIL stop_resume got %0d exp 2", ss); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h20 + 32'(i * 4), 0, 0, 0, 0);
    cycle(1, 32'h30, 1, 0, 0, 0);
    checks++; if (vw !== 1'b1 || dw !== rec(32'h20) || cw !== 3'd4 || ow !== 1'b0) begin
      errors++; $display("FAIL b2b_w got v=%0d pc=%h cnt=%0d ovf=%0d exp v=1 pc=20 cnt=4 ovf=0", vw, dw[31:0], cw, ow); end
    checks++; if (vs !== 1'b1 || ds !== rec(32'h20) || cs !== 3'd4 || os !== 1'b0 || ss !== 2'd3) begin
      errors++; $display("FAIL b2b_s got v=%0d pc=%h cnt=%0d ovf=%0d st=%0d exp v=1 pc=20 cnt=4 ovf=0 st=3", vs, ds[31:0], cs, os, ss); end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      checks++; if (dw !== rec(32'h24 + 32'(i * 4)) || ds !== rec(32'h24 + 32'(i * 4))) begin
        errors++; $display("FAIL b2b_drain%0d got w=%h s=%h exp %h", i, dw[31:0], ds[31:0], 32'h24 + 32'(i * 4)); end
    end
    cycle(0, 0, 1, 0, 0, 0);
    checks++; if (vw !== 1'b0 || vs !== 1'b0 || dw !== rec(32'h30) || cw !== 3'd0) begin
      errors++; $display("FAIL pop_empty got v=%0d/%0d pc=%h cnt=%0d exp v=0 pc=30 cnt=0", vw, vs, dw[31:0], cw); end
  endtask

  task automatic test_clear_stop();
    do_reset();
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 32'h50 + 32'(i * 4), 0, 0, 0, 0);
    trig_en = 1'b1;
    cycle(0, 0, 0, 1, 0, 0);
    trig_en = 1'b0;
    checks++; if (sw !== 2'd2) begin errors++; $display("FAIL arm_ignored got %0d exp 2", sw); end
    cycle(1, 32'h64, 1, 0, 0, 1);
    checks++; if (cw !== 3'd0 || ow !== 1'b0 || sw !== 2'd2 || vw !== 1'b0) begin
      errors++; $display("FAIL clear_w got cnt=%0d ovf=%0d st=%0d v=%0d exp cnt=0 ovf=0 st=2 v=0", cw, ow, sw, vw); end
    checks++; if (cs !== 3'd0 || os !== 1'b0 || ss !== 2'd3) begin
      errors++; $display("FAIL clear_s got cnt=%0d ovf=%0d st=%0d exp cnt=0 ovf=0 st=3", cs, os, ss); end
    cycle(1, 32'h68, 0, 0, 1, 0);
    checks++; if (cw !== 3'd1 || sw !== 2'd0 || cs !== 3'd1 || ss !== 2'd0) begin
      errors++; $display("FAIL stop_capture got cnt=%0d/%0d st=%0d/%0d exp cnt=1 st=0", cw, cs, sw, ss); end
    cycle(0, 0, 1, 0, 0, 0);
    checks++; if (vw !== 1'b1 || dw !== rec(32'h68) || ds !== rec(32'h68)) begin
      errors++; $display("FAIL stop_pop got v=%0d pc=%h/%h exp v=1 pc=68", vw, dw[31:0], ds[31:0]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'h70 + 32'(i * 4), 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    checks++; if (vw !== 1'b1 || cw !== 3'd3) begin
      errors++; $display("FAIL pre_reset got v=%0d cnt=%0d exp v=1 cnt=3", vw, cw); end
    Reset = 1'b1;
    #1;
    checks++; if (cw !== 3'd0 || sw !== 2'd0 || vw !== 1'b0 || cs !== 3'd0 || ss !== 2'd0) begin
      errors++; $display("FAIL async_reset got cnt=%0d st=%0d v=%0d exp 0", cw, sw, vw); end
    Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trigger();
    test_wrap_stop();
    test_back_to_back();
    test_clear_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
